// File: rtl/mul_wb_merge_pkg.sv
// Shared writeback types and the squash predicate used by every execution unit.
package mul_wb_merge_pkg;
    localparam int SQN_W   = 7;
    localparam int TAG_W   = 7;
    localparam int FLAGS_W = 4;
    localparam int DATA_W  = 32;

    typedef logic [SQN_W-1:0]   SqN;
    typedef logic [FLAGS_W-1:0] Flags;

    localparam Flags FLAGS_NONE = '0;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [TAG_W-1:0]  tagDst;
        SqN                sqN;
        Flags              flags;
        logic              doNotCommit;
        logic              valid;
    } RES_UOp;

    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;

    // Younger than the taken branch (sqN compared modulo wrap) means squashed.
    function automatic logic is_killed(input SqN uop_sqn, input BranchProv br);
        logic signed [SQN_W-1:0] d;
        d = uop_sqn - br.sqN;
        return br.taken && (d > 0);
    endfunction
endpackage

// File: rtl/res_fifo.sv
// Ordered result FIFO with push, pop and truncate-to-N; exposes entries in head-relative order.
module res_fifo
    import mul_wb_merge_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  RES_UOp                 push_data,
    input  logic                   pop,
    input  logic                   trunc,
    input  logic [CNT_W-1:0]       trunc_cnt,
    output logic [CNT_W-1:0]       count,
    output RES_UOp                 head_data,
    output RES_UOp [DEPTH-1:0]     entries
);
    RES_UOp           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [CNT_W-1:0] cnt_q, keep, keep_pop;

    // Sum stays below 2*DEPTH, so one conditional subtract wraps any DEPTH.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    always_comb begin
        keep     = trunc ? trunc_cnt : cnt_q;
        keep_pop = keep - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            cnt_q <= '0;
        end else begin
            if (pop) head <= wrap_add(head, 1);
            cnt_q <= keep_pop + CNT_W'(push);
        end
    end

    // Push slot is taken relative to the pre-pop head, i.e. right after the survivors.
    always_ff @(posedge clk) begin
        if (push) mem[wrap_add(head, int'(keep))] <= push_data;
    end

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_ent
            assign entries[i] = mem[wrap_add(head, i)];
        end
    endgenerate

    assign head_data = entries[0];
    assign count     = cnt_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && keep_pop == CNT_W'(DEPTH)));
endmodule

// File: rtl/mul_wb_merge.sv
// Shares the result bus between ALU (always wins) and multiplier (FIFO-buffered), dropping squashed uops.
module mul_wb_merge
    import mul_wb_merge_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int INFLIGHT = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  BranchProv IN_branch,
    input  RES_UOp    IN_aluUop,
    input  RES_UOp    IN_mulUop,
    output logic      OUT_mulBusy,
    output RES_UOp    OUT_uop
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]   count, keep;
    RES_UOp             head;
    RES_UOp [DEPTH-1:0] entries;
    logic [DEPTH-1:0]   ent_live;
    logic               alu_ok, mul_ok, pop, push, bypass;
    RES_UOp             nxt;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_live
            assign ent_live[i] = (CNT_W'(i) < count) && !is_killed(entries[i].sqN, IN_branch);
        end
    endgenerate

    // Entries are sqN-ordered, so live entries are exactly the surviving head prefix.
    always_comb begin
        keep = '0;
        for (int k = 0; k < DEPTH; k++) keep = keep + CNT_W'(ent_live[k]);
    end

    always_comb begin
        alu_ok = IN_aluUop.valid && !is_killed(IN_aluUop.sqN, IN_branch);
        mul_ok = IN_mulUop.valid && !is_killed(IN_mulUop.sqN, IN_branch);
        pop    = !alu_ok && (keep != '0);
        bypass = !alu_ok && (keep == '0) && mul_ok;
        push   = mul_ok && !bypass;
        nxt    = '0;
        if (alu_ok)      nxt = IN_aluUop;
        else if (pop)    nxt = head;
        else if (bypass) nxt = IN_mulUop;
    end

    res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (IN_mulUop),
        .pop       (pop),
        .trunc     (IN_branch.taken),
        .trunc_cnt (keep),
        .count     (count),
        .head_data (head),
        .entries   (entries)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) OUT_uop <= '0;
        else      OUT_uop <= nxt;
    end

    assign OUT_mulBusy = (count >= CNT_W'(DEPTH - INFLIGHT));
endmodule

// File: tb/tb_mul_wb_merge.sv
// Directed scenarios on an 8/3 instance, randomised queue-model traffic on a 5/4 instance.
module tb_mul_wb_merge;
    import mul_wb_merge_pkg::*;

    localparam int INF_B = 4;
    localparam int N_RND = 2000;

    logic      clk = 0;
    logic      rst = 1;
    BranchProv br_a = '0, br_b = '0;
    RES_UOp    alu_a = '0, mul_a = '0, alu_b = '0, mul_b = '0;
    RES_UOp    out_a, out_b;
    logic      busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_wb_merge #(.DEPTH(8), .INFLIGHT(3)) dut_a (
        .clk(clk), .rst(rst), .IN_branch(br_a), .IN_aluUop(alu_a), .IN_mulUop(mul_a),
        .OUT_mulBusy(busy_a), .OUT_uop(out_a));

    mul_wb_merge #(.DEPTH(5), .INFLIGHT(INF_B)) dut_b (
        .clk(clk), .rst(rst), .IN_branch(br_b), .IN_aluUop(alu_b), .IN_mulUop(mul_b),
        .OUT_mulBusy(busy_b), .OUT_uop(out_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_uop(input string tag, input RES_UOp got, input RES_UOp exp);
        if (exp.valid) chk(tag, 64'(got), 64'(exp));
        else           chk(tag, 64'(got.valid), 64'(1'b0));
    endtask

    function automatic RES_UOp mk(input SqN s, input logic [31:0] r);
        RES_UOp u;
        u        = '0;
        u.valid  = 1'b1;
        u.sqN    = s;
        u.result = r;
        u.tagDst = s;
        u.flags  = FLAGS_NONE;
        return u;
    endfunction

    function automatic logic kil(input RES_UOp u, input BranchProv b);
        logic signed [SQN_W-1:0] d;
        d = u.sqN - b.sqN;
        return b.taken && (d > 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    RES_UOp inv = '0;

    initial begin
        RES_UOp e, exp_out;
        RES_UOp q[$];
        RES_UOp qn[$];
        RES_UOp pipe[INF_B-1];
        SqN     mseq;
        logic   used;

        #1 rst = 0;
        #11;
        chk("rst_out_a", 64'(out_a.valid), 64'(1'b0));
        chk("rst_busy_a", 64'(busy_a), 64'(1'b0));
        chk("rst_out_b", 64'(out_b.valid), 64'(1'b0));
        chk("rst_busy_b", 64'(busy_b), 64'(1'b0));
        @(negedge clk) rst = 1;
        tick();

        // mul bypass on an idle FIFO, all fields passed through
        e = mk(7'd5, 32'h12345678);
        e.tagDst = 7'd9; e.flags = 4'h3; e.doNotCommit = 1'b1;
        mul_a = e;
        tick();
        chk_uop("t1_bypass", out_a, e);
        mul_a = '0;
        tick();
        chk_uop("t1_empty", out_a, inv);

        // ALU wins, mul follows
        alu_a = mk(7'd40, 32'hA1); mul_a = mk(7'd7, 32'h77);
        tick();
        chk_uop("t2_alu", out_a, mk(7'd40, 32'hA1));
        alu_a = '0; mul_a = '0;
        tick();
        chk_uop("t2_mul", out_a, mk(7'd7, 32'h77));
        tick();
        chk_uop("t2_empty", out_a, inv);

        // sustained ALU, mul backs up until busy, then drains in order
        for (int k = 0; k < 5; k++) begin
            chk("t3_busy_fill", 64'(busy_a), 64'(1'b0));
            alu_a = mk(SqN'(50 + k), 32'(k)); mul_a = mk(SqN'(10 + k), 32'(100 + k));
            tick();
            chk_uop("t3_alu", out_a, mk(SqN'(50 + k), 32'(k)));
        end
        alu_a = '0; mul_a = '0;
        chk("t3_busy_full", 64'(busy_a), 64'(1'b1));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_uop("t3_drain", out_a, mk(SqN'(10 + k), 32'(100 + k)));
            if (k == 0) chk("t3_busy_drop", 64'(busy_a), 64'(1'b0));
        end
        tick();
        chk_uop("t3_empty", out_a, inv);

        // flush tail while head pops; same-cycle younger mul dropped
        for (int k = 0; k < 4; k++) begin
            alu_a = mk(SqN'(60 + k), 32'(k)); mul_a = mk(SqN'(20 + k), 32'(200 + k));
            tick();
        end
        alu_a = '0;
        br_a = '{taken: 1'b1, sqN: 7'd21};
        mul_a = mk(7'd24, 32'd224);
        tick();
        chk_uop("t4_pop20", out_a, mk(7'd20, 32'd200));
        br_a = '0; mul_a = '0;
        tick();
        chk_uop("t4_keep21", out_a, mk(7'd21, 32'd201));
        tick();
        chk_uop("t4_empty", out_a, inv);

        // asynchronous reset mid-operation
        for (int k = 0; k < 5; k++) begin
            alu_a = mk(SqN'(70 + k), 32'(k)); mul_a = mk(SqN'(30 + k), 32'(k));
            tick();
        end
        alu_a = '0; mul_a = '0;
        chk("t5_pre_busy", 64'(busy_a), 64'(1'b1));
        chk("t5_pre_valid", 64'(out_a.valid), 64'(1'b1));
        #2 rst = 0;
        #1;
        chk("t5_async_out", 64'(out_a.valid), 64'(1'b0));
        chk("t5_async_busy", 64'(busy_a), 64'(1'b0));
        @(negedge clk) rst = 1;
        tick();
        mul_a = mk(7'd40, 32'hBEEF);
        tick();
        chk_uop("t5_bypass", out_a, mk(7'd40, 32'hBEEF));
        mul_a = '0;
        tick();
        chk_uop("t5_empty", out_a, inv);

        // randomised traffic on the 5/4 instance against a queue model
        mseq = 7'd0;
        for (int k = 0; k < INF_B - 1; k++) pipe[k] = '0;
        for (int c = 0; c < N_RND + 40; c++) begin
            mul_b = pipe[INF_B-2];
            for (int k = INF_B - 2; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = '0;
            if (c < N_RND && !busy_b && $urandom_range(0, 2) != 0) begin
                pipe[0] = mk(mseq, $urandom);
                mseq = mseq + 7'd1;
            end
            alu_b = '0;
            if (c < N_RND && $urandom_range(0, 1) == 1)
                alu_b = mk(SqN'(int'(mseq) + $urandom_range(0, 3) - 2), $urandom);
            br_b = '0;
            if (c < N_RND && $urandom_range(0, 7) == 0)
                br_b = '{taken: 1'b1, sqN: SqN'(int'(mseq) - $urandom_range(1, 8))};

            chk("rnd_busy", 64'(busy_b), 64'(q.size() >= 1));

            qn = {};
            foreach (q[k]) if (!kil(q[k], br_b)) qn.push_back(q[k]);
            q = qn;
            exp_out = '0;
            used = 1'b0;
            if (alu_b.valid && !kil(alu_b, br_b)) exp_out = alu_b;
            else if (q.size() > 0) exp_out = q.pop_front();
            else if (mul_b.valid && !kil(mul_b, br_b)) begin
                exp_out = mul_b;
                used = 1'b1;
            end
            if (mul_b.valid && !kil(mul_b, br_b) && !used) q.push_back(mul_b);

            tick();
            chk_uop("rnd_out", out_b, exp_out);
        end
        chk("rnd_drained", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
